mips_multicycle_ctrl: RTL
=========================

# mips_multicycle_ctrl

Multi-cycle sequencer for the MIPS core: replaces single-cycle control decode with a state machine that reuses one ALU and one unified instruction/data memory across several cycles per instruction. Drives the datapath's PC, instruction register, memory, register-file and ALU mux controls. Tolerates variable-latency memory through a ready handshake with a timeout watchdog. Supports add, sub, and, or, slt, addi, lw, sw, beq and j; any other encoding traps.

## Interface
- WAIT_MAX, 15: maximum consecutive cycles with MEM_READY low in one memory state before a bus error (1..255).
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- OPCODE  in  6  IR[31:26], valid from DECODE onward.
- FUNCT  in  6  IR[5:0].
- ZERO  in  1  ALU zero flag.
- MEM_READY  in  1  memory completes the current access this cycle.
- PC_WRITE, IR_WRITE  out  1  load PC / instruction register.
- I_OR_D  out  1  memory address source: 0 = PC, 1 = ALUOut.
- MEM_READ, MEM_WRITE  out  1  memory access strobes.
- REG_DST  out  1  destination register: 1 = rd, 0 = rt.
- REG_WRITE  out  1  register-file write enable.
- MEM2REG  out  1  write-back source: 1 = ALUOut, 0 = memory data register.
- ALU_SRC_A  out  1  ALU operand A: 0 = PC, 1 = register A.
- ALU_SRC_B  out  2  ALU operand B: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALU_OP  out  4  ALU operation: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
- PC_SRC  out  2  next-PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- INSTR_DONE  out  1  one-cycle pulse on the instruction's final cycle.
- STATE  out  4  current state encoding, for debug.
- ILLEGAL, BUS_ERR  out  1  sticky trap causes.

## Operation
- States and encodings:
  - FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5
  - R_EXEC 6, R_WB 7, I_EXEC 8, I_WB 9, BRANCH 10, JUMP 11, TRAP 15.
- Outputs are a Moore decode of STATE, with two exceptions:
  - IR_WRITE and PC_WRITE in FETCH are gated by MEM_READY.
  - PC_WRITE in BRANCH is gated by ZERO.
- Any output not listed for a state is 0.
- FETCH:
  - I_OR_D=0, MEM_READ=1, ALU_SRC_A=0, ALU_SRC_B=01, ALU_OP=add, PC_SRC=00.
  - If MEM_READY: IR_WRITE=PC_WRITE=1, go to DECODE; otherwise stay.
- DECODE (branch target precompute):
  - ALU_SRC_A=0, ALU_SRC_B=11, ALU_OP=add.
  - Dispatch on OPCODE: lw/sw to MEM_ADDR; R-type to R_EXEC; addi to I_EXEC; beq to BRANCH; j to JUMP.
  - Unknown opcode, or R-type with unknown FUNCT: go to TRAP and set ILLEGAL.
- MEM_ADDR: ALU_SRC_A=1, ALU_SRC_B=10, add; then lw to MEM_RD, sw to MEM_WR.
- MEM_RD: I_OR_D=1, MEM_READ=1; wait for MEM_READY, then go to MEM_WB.
- MEM_WB: REG_WRITE=1, REG_DST=0, MEM2REG=0, INSTR_DONE=1; go to FETCH.
- MEM_WR: I_OR_D=1, MEM_WRITE=1; wait for MEM_READY; INSTR_DONE=1 in the ready cycle; go to FETCH.
- R_EXEC: ALU_SRC_A=1, ALU_SRC_B=00, ALU_OP from the FUNCT decode; go to R_WB.
- R_WB: REG_WRITE=1, REG_DST=1, MEM2REG=1, INSTR_DONE=1; go to FETCH.
- I_EXEC: ALU_SRC_A=1, ALU_SRC_B=10, add; go to I_WB.
- I_WB: REG_WRITE=1, REG_DST=0, MEM2REG=1, INSTR_DONE=1; go to FETCH.
- BRANCH: ALU_SRC_A=1, ALU_SRC_B=00, sub, PC_SRC=01, PC_WRITE=ZERO, INSTR_DONE=1; go to FETCH.
- JUMP: PC_SRC=10, PC_WRITE=1, INSTR_DONE=1; go to FETCH.
- Wait counter (8 bits):
  - Cleared on entering any memory state, and whenever MEM_READY=1.
  - Increments each cycle MEM_READY=0 in FETCH, MEM_RD or MEM_WR.
  - When it reaches WAIT_MAX with MEM_READY still 0: go to TRAP and set BUS_ERR. No strobes are issued in TRAP.
- TRAP:
  - All strobes 0; PC and IR are never written.
  - Remains in TRAP until RST; ILLEGAL and BUS_ERR stay asserted.

## Timing
- Reset:
  - RST sampled high forces STATE=FETCH, wait counter 0, ILLEGAL=BUS_ERR=0 on the next edge.
  - While RST is high, all write and strobe outputs are forced to 0 combinationally.
- RST mid-instruction aborts the instruction with no write: a MEM_READY in the same cycle is ignored.
- Latency with zero wait states:
  - beq and j: 3 cycles.
  - R-type, addi and sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds 1 cycle.
- Memory strobes and I_OR_D stay stable for every cycle of a wait.
- MEM_READY arriving in the same cycle the counter hits WAIT_MAX counts as success; no trap.
- INSTR_DONE pulses exactly once per retired instruction; it never pulses in TRAP.

## Structure
- Package mips_ctrl_pkg holds:
  - the state enum and its encodings;
  - opcode constants (000000, 001000, 100011, 101011, 000100, 000010);
  - funct constants (100000, 100010, 100100, 100101, 101010);
  - ALU_OP codes and ALU_SRC_B / PC_SRC selector codes.
- Sub-module mips_alu_dec: combinational FUNCT to {ALU_OP, valid}, used in DECODE (legality check) and R_EXEC.

## Test plan
- Reset, then add with MEM_READY=1 always: states 0,1,6,7,0; REG_WRITE=1 and REG_DST=1 only in cycle 4; INSTR_DONE in cycle 4.
- lw with 3 wait cycles on both the fetch and the data read: 11 cycles; MEM_READ and I_OR_D stable through the waits; IR_WRITE exactly once.
- beq with ZERO=1, then beq with ZERO=0: PC_WRITE=1 in BRANCH only in the first case; both take 3 cycles.
- Opcode 111111, and a separate case of R-type FUNCT 000111: TRAP, ILLEGAL=1, no further strobes; RST returns to FETCH with ILLEGAL=0.
- WAIT_MAX=4, MEM_READY held low in MEM_WR: after 4 wait cycles, TRAP with BUS_ERR=1. Repeat with MEM_READY=1 in the 4th wait cycle: no trap, INSTR_DONE=1.
- RST asserted in MEM_RD in the same cycle as MEM_READY=1: no REG_WRITE; STATE=FETCH next cycle.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer:
// states, opcode/funct values and datapath mux selector codes.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EXEC   = 4'd6,
      S_R_WB     = 4'd7,
      S_I_EXEC   = 4'd8,
      S_I_WB     = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_TRAP     = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States that own the memory bus and are covered by the wait watchdog.
   function automatic logic is_mem_state(state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_dec.sv
// R-type FUNCT decoder: ALU operation plus a legality flag.
module mips_alu_dec
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] funct_i,
   output logic [3:0] alu_op_o,
   output logic       valid_o
);

   always_comb begin
      alu_op_o = ALU_ADD;
      valid_o  = 1'b1;
      case (funct_i)
         FN_ADD:  alu_op_o = ALU_ADD;
         FN_SUB:  alu_op_o = ALU_SUB;
         FN_AND:  alu_op_o = ALU_AND;
         FN_OR:   alu_op_o = ALU_OR;
         FN_SLT:  alu_op_o = ALU_SLT;
         default: begin
            alu_op_o = ALU_ADD;
            valid_o  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer with a memory-ready watchdog.
// Outputs are a Moore decode of the state register, gated by reset.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 15
)
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output logic       pc_write_o,
   output logic       ir_write_o,
   output logic       i_or_d_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       reg_dst_o,
   output logic       reg_write_o,
   output logic       mem2reg_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [3:0] alu_op_o,
   output logic [1:0] pc_src_o,
   output logic       instr_done_o,
   output logic [3:0] state_o,
   output logic       illegal_o,
   output logic       bus_err_o
);

   // The trap fires on the low cycle that would bring the count up to WAIT_MAX.
   localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

   state_t     state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic       illegal_q, illegal_d;
   logic       bus_err_q, bus_err_d;
   logic [3:0] dec_alu_op;
   logic       dec_valid;

   mips_alu_dec u_alu_dec (
      .funct_i  (funct_i),
      .alu_op_o (dec_alu_op),
      .valid_o  (dec_valid)
   );

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      case (state_q)
         S_FETCH:    if (mem_ready_i) state_d = S_DECODE; else state_d = S_FETCH;
         S_DECODE: begin
            case (opcode_i)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_ADDI:      state_d = S_I_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_RTYPE: begin
                  if (dec_valid) begin
                     state_d = S_R_EXEC;
                  end else begin
                     state_d   = S_TRAP;
                     illegal_d = 1'b1;
                  end
               end
               default: begin
                  state_d   = S_TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: if (opcode_i == OP_SW) state_d = S_MEM_WR; else state_d = S_MEM_RD;
         S_MEM_RD:   if (mem_ready_i) state_d = S_MEM_WB; else state_d = S_MEM_RD;
         S_MEM_WR:   if (mem_ready_i) state_d = S_FETCH; else state_d = S_MEM_WR;
         S_R_EXEC:   state_d = S_R_WB;
         S_I_EXEC:   state_d = S_I_WB;
         S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_TRAP;
      endcase

      // Memory states leave only on ready, so entry always sees a cleared count.
      if (is_mem_state(state_q)) begin
         if (mem_ready_i) begin
            wait_d = 8'd0;
         end else if (wait_q >= WAIT_LAST) begin
            wait_d    = wait_q + 8'd1;
            state_d   = S_TRAP;
            bus_err_d = 1'b1;
         end else begin
            wait_d = wait_q + 8'd1;
         end
      end else begin
         wait_d = 8'd0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_FETCH;
         wait_q    <= 8'd0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   always_comb begin
      pc_write_o   = 1'b0;
      ir_write_o   = 1'b0;
      i_or_d_o     = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      reg_dst_o    = 1'b0;
      reg_write_o  = 1'b0;
      mem2reg_o    = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = SRCB_REG;
      alu_op_o     = 4'b0000;
      pc_src_o     = PCSRC_ALU;
      instr_done_o = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = SRCB_FOUR;
            alu_op_o    = ALU_ADD;
            ir_write_o  = mem_ready_i;
            pc_write_o  = mem_ready_i;
         end
         S_DECODE: begin
            alu_src_b_o = SRCB_IMM_SH2;
            alu_op_o    = ALU_ADD;
         end
         S_MEM_ADDR, S_I_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRCB_IMM;
            alu_op_o    = ALU_ADD;
         end
         S_MEM_RD: begin
            i_or_d_o   = 1'b1;
            mem_read_o = 1'b1;
         end
         S_MEM_WB: begin
            reg_write_o  = 1'b1;
            instr_done_o = 1'b1;
         end
         S_MEM_WR: begin
            i_or_d_o     = 1'b1;
            mem_write_o  = 1'b1;
            instr_done_o = mem_ready_i;
         end
         S_R_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = dec_alu_op;
         end
         S_R_WB: begin
            reg_write_o  = 1'b1;
            reg_dst_o    = 1'b1;
            mem2reg_o    = 1'b1;
            instr_done_o = 1'b1;
         end
         S_I_WB: begin
            reg_write_o  = 1'b1;
            mem2reg_o    = 1'b1;
            instr_done_o = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a_o  = 1'b1;
            alu_op_o     = ALU_SUB;
            pc_src_o     = PCSRC_ALUOUT;
            pc_write_o   = zero_i;
            instr_done_o = 1'b1;
         end
         S_JUMP: begin
            pc_src_o     = PCSRC_JUMP;
            pc_write_o   = 1'b1;
            instr_done_o = 1'b1;
         end
         default: begin
            pc_write_o = 1'b0;
         end
      endcase

      // Reset aborts the instruction in flight, including a same-cycle ready.
      if (rst_i) begin
         pc_write_o   = 1'b0;
         ir_write_o   = 1'b0;
         mem_read_o   = 1'b0;
         mem_write_o  = 1'b0;
         reg_write_o  = 1'b0;
         instr_done_o = 1'b0;
      end else begin
         instr_done_o = instr_done_o;
      end
   end

   assign state_o   = state_q;
   assign illegal_o = illegal_q;
   assign bus_err_o = bus_err_q;

endmodule
